// File: rtl/header_gen.sv
`default_nettype none
// ============================================================================
// Module      : header_gen
// Description : Transmit-side Ethernet header generator. On a start request
//               it emits a 22-byte header (7x 0x55 preamble, 0xD5 SFD,
//               destination address, source address, type/length) one byte
//               per accepted valid/ready transfer. Byte order matches the
//               receive-side header parser for back-to-back loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module header_gen #(
    parameter logic [47:0] DST_ADDR    = 48'h010203040506,
    parameter logic [47:0] SRC_ADDR    = 48'hFFFEFDFCFBFA,
    parameter logic [15:0] TYPE_LENGTH = 16'h0800
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [1:0] field,
    output logic       field_last,
    output logic       busy,
    output logic       done
);

    // State encoding
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_pre  = 3'd1;
    localparam logic [2:0] c_st_sfd  = 3'd2;
    localparam logic [2:0] c_st_dst  = 3'd3;
    localparam logic [2:0] c_st_src  = 3'd4;
    localparam logic [2:0] c_st_type = 3'd5;

    // Field codes presented on the field output
    localparam logic [1:0] c_fld_pre  = 2'd0;
    localparam logic [1:0] c_fld_dst  = 2'd1;
    localparam logic [1:0] c_fld_src  = 2'd2;
    localparam logic [1:0] c_fld_type = 2'd3;

    localparam logic [7:0] c_preamble = 8'h55;
    localparam logic [7:0] c_sfd      = 8'hD5;

    // Registered state and outputs
    logic [2:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic [1:0] r_field;
    logic       r_field_last;
    logic       r_busy;
    logic       r_done;

    // Next position after a transfer, and the byte presented there
    logic [2:0] w_nxt_state;
    logic [2:0] w_nxt_cnt;
    logic       w_hdr_end;
    logic [7:0] w_byte;
    logic [1:0] w_field;
    logic       w_field_last;

    // Advance the (state, byte counter) position by one accepted byte
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 3'd1;
        w_hdr_end   = 1'b0;
        case (r_state)
            c_st_pre: begin
                if (r_cnt == 3'd6) begin
                    w_nxt_state = c_st_sfd;
                    w_nxt_cnt   = 3'd0;
                end
            end
            c_st_sfd: begin
                w_nxt_state = c_st_dst;
                w_nxt_cnt   = 3'd0;
            end
            c_st_dst: begin
                if (r_cnt == 3'd5) begin
                    w_nxt_state = c_st_src;
                    w_nxt_cnt   = 3'd0;
                end
            end
            c_st_src: begin
                if (r_cnt == 3'd5) begin
                    w_nxt_state = c_st_type;
                    w_nxt_cnt   = 3'd0;
                end
            end
            c_st_type: begin
                if (r_cnt == 3'd1) begin
                    w_nxt_state = c_st_idle;
                    w_nxt_cnt   = 3'd0;
                    w_hdr_end   = 1'b1;
                end
            end
            default: begin
                w_nxt_state = c_st_idle;
                w_nxt_cnt   = 3'd0;
            end
        endcase
    end

    // Byte, field code and field-last flag for the next position; IDLE yields zeros
    always_comb begin
        w_byte       = 8'h00;
        w_field      = c_fld_pre;
        w_field_last = 1'b0;
        case (w_nxt_state)
            c_st_pre: begin
                w_byte = c_preamble;
            end
            c_st_sfd: begin
                w_byte       = c_sfd;
                w_field_last = 1'b1;
            end
            c_st_dst: begin
                w_field      = c_fld_dst;
                w_field_last = (w_nxt_cnt == 3'd5);
                case (w_nxt_cnt)
                    3'd0:    w_byte = DST_ADDR[47:40];
                    3'd1:    w_byte = DST_ADDR[39:32];
                    3'd2:    w_byte = DST_ADDR[31:24];
                    3'd3:    w_byte = DST_ADDR[23:16];
                    3'd4:    w_byte = DST_ADDR[15:8];
                    default: w_byte = DST_ADDR[7:0];
                endcase
            end
            c_st_src: begin
                w_field      = c_fld_src;
                w_field_last = (w_nxt_cnt == 3'd5);
                case (w_nxt_cnt)
                    3'd0:    w_byte = SRC_ADDR[47:40];
                    3'd1:    w_byte = SRC_ADDR[39:32];
                    3'd2:    w_byte = SRC_ADDR[31:24];
                    3'd3:    w_byte = SRC_ADDR[23:16];
                    3'd4:    w_byte = SRC_ADDR[15:8];
                    default: w_byte = SRC_ADDR[7:0];
                endcase
            end
            c_st_type: begin
                w_field      = c_fld_type;
                w_field_last = (w_nxt_cnt == 3'd1);
                w_byte       = (w_nxt_cnt == 3'd0) ? TYPE_LENGTH[15:8] : TYPE_LENGTH[7:0];
            end
            default: begin
                w_byte = 8'h00;
            end
        endcase
    end

    // Main sequencer: start from IDLE, abort beats transfer, stall holds everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_cnt        <= 3'd0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_field      <= c_fld_pre;
            r_field_last <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_st_idle) begin
                // abort is meaningless here, so a simultaneous start still wins
                if (start) begin
                    r_state      <= c_st_pre;
                    r_cnt        <= 3'd0;
                    r_data_out   <= c_preamble;
                    r_data_valid <= 1'b1;
                    r_field      <= c_fld_pre;
                    r_field_last <= 1'b0;
                    r_busy       <= 1'b1;
                end
            end else if (abort) begin
                r_state      <= c_st_idle;
                r_cnt        <= 3'd0;
                r_data_out   <= 8'h00;
                r_data_valid <= 1'b0;
                r_field      <= c_fld_pre;
                r_field_last <= 1'b0;
                r_busy       <= 1'b0;
            end else if (data_ready) begin
                // data_valid is always high outside IDLE, so ready alone means a transfer
                r_state      <= w_nxt_state;
                r_cnt        <= w_nxt_cnt;
                r_data_out   <= w_byte;
                r_field      <= w_field;
                r_field_last <= w_field_last;
                r_data_valid <= ~w_hdr_end;
                r_busy       <= ~w_hdr_end;
                r_done       <= w_hdr_end;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign field      = r_field;
    assign field_last = r_field_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_header_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_header_gen
// Description : Scoreboard bench for header_gen. The driver pushes the
//               expected byte stream for each header; a negedge monitor pops
//               and compares on every accepted transfer and tracks done,
//               busy and stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_header_gen;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic [1:0] field;
    logic       field_last;
    logic       busy;
    logic       done;

    header_gen u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .field      (field),
        .field_last (field_last),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] f;
        logic       fl;
        logic       hend;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    // Hand-written header image
    logic [7:0] c_hdr [22] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA,
                               8'h08, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the first nbytes of one header; only a complete header ends in done
    task automatic push_header(input int nbytes);
        exp_t e;
        for (int i = 0; i < nbytes; i++) begin
            e.b    = c_hdr[i];
            e.f    = (i < 8) ? 2'd0 : (i < 14) ? 2'd1 : (i < 20) ? 2'd2 : 2'd3;
            e.fl   = (i == 7 || i == 13 || i == 19 || i == 21);
            e.hend = (nbytes == 22 && i == 21);
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Monitor: transfer scoreboard, done timing, busy/valid tracking, stall hold
    logic       exp_done_next = 1'b0;
    logic       prev_stall    = 1'b0;
    logic [7:0] prev_data     = 8'h00;
    logic [1:0] prev_field    = 2'd0;
    logic       prev_fl       = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            chk("done", {31'd0, done}, {31'd0, exp_done_next});
            exp_done_next = 1'b0;
            chk("busy_vs_valid", {31'd0, busy}, {31'd0, data_valid});
            if (prev_stall) begin
                chk("stall_valid", {31'd0, data_valid}, 32'd1);
                chk("stall_data", {24'd0, data_out}, {24'd0, prev_data});
                chk("stall_field", {30'd0, field}, {30'd0, prev_field});
                chk("stall_last", {31'd0, field_last}, {31'd0, prev_fl});
            end
            if (data_valid && data_ready && !abort && reset_n) begin
                if (q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("data_out", {24'd0, data_out}, {24'd0, e.b});
                    chk("field", {30'd0, field}, {30'd0, e.f});
                    chk("field_last", {31'd0, field_last}, {31'd0, e.fl});
                    exp_done_next = e.hend;
                end
            end
            prev_stall = data_valid && !data_ready && !abort && reset_n;
            prev_data  = data_out;
            prev_field = field;
            prev_fl    = field_last;
        end
    end

    task automatic chk_reset_vals(input string name);
        chk({name, "_data_out"}, {24'd0, data_out}, 32'd0);
        chk({name, "_valid"}, {31'd0, data_valid}, 32'd0);
        chk({name, "_field"}, {30'd0, field}, 32'd0);
        chk({name, "_last"}, {31'd0, field_last}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        bit found;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        data_ready = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // Full header at full rate: latency and done timing
        push_header(22);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_first_valid", {31'd0, data_valid}, 32'd1);
        chk("t1_first_byte", {24'd0, data_out}, 32'h55);
        chk("t1_first_busy", {31'd0, busy}, 32'd1);
        repeat (21) tick();
        chk("t1_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Random back-pressure with a start pulse while busy
        push_header(22);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            data_ready = 1'($urandom_range(0, 1));
            start      = (i == 5);
            tick();
            if (done === 1'b1) found = 1'b1;
        end
        start      = 1'b0;
        data_ready = 1'b1;
        chk("t2_done_seen", {31'd0, found}, 32'd1);
        repeat (2) tick();

        // Abort while 0xFC is presented: FC never transfers, no done
        push_header(17);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (data_valid && data_out == 8'hFC) found = 1'b1;
            else tick();
        end
        chk("t3_fc_seen", {31'd0, found}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_valid_after_abort", {31'd0, data_valid}, 32'd0);
        chk("t3_busy_after_abort", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        push_header(22);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_restart_byte", {24'd0, data_out}, 32'h55);
        wait_done("t3");
        tick();

        // Start held high: back-to-back headers with one idle (done) cycle
        push_header(22);
        push_header(22);
        start = 1'b1;
        tick();
        wait_done("t4a");
        chk("t4_gap_valid", {31'd0, data_valid}, 32'd0);
        tick();
        start = 1'b0;
        chk("t4_second_valid", {31'd0, data_valid}, 32'd1);
        chk("t4_second_byte", {24'd0, data_out}, 32'h55);
        repeat (4) tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done("t4b");
        repeat (3) tick();
        chk("t4_no_third", {31'd0, busy}, 32'd0);

        // Reset pulse while DST byte 0x03 is presented
        push_header(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (data_valid && data_out == 8'h03 && field == 2'd1) found = 1'b1;
            else tick();
        end
        chk("t5_03_seen", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_vals("t5_reset");
        tick();
        push_header(22);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5");
        repeat (3) tick();

        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/header_gen.md
# header_gen

Transmit-side Ethernet header generator: on a start request it emits the 22-byte header one byte per accepted transfer. The header is 7×0x55 preamble, 0xD5 SFD, 6-byte destination address, 6-byte source address and 2-byte type/length. Its byte sequence matches exactly what the receive-side header parser accepts, so the two blocks connect back to back in loopback benches. The generator sits upstream of the MAC byte serializer and drives it through a valid/ready byte handshake.

## Interface
- DST_ADDR, 48'h010203040506, destination address, sent MSB byte first
- SRC_ADDR, 48'hFFFEFDFCFBFA, source address, sent MSB byte first
- TYPE_LENGTH, 16'h0800, type/length, sent MSB byte first
- clock  input  1  rising-edge clock, sole clock
- reset_n  input  1  synchronous reset, active low; sampled on the rising edge of clock
- start  input  1  request one header; sampled only in IDLE
- abort  input  1  terminate the current header immediately
- data_ready  input  1  downstream accepts data_out this cycle
- data_out  output  8  header byte
- data_valid  output  1  data_out is valid
- field  output  2  field of the current byte: 0 = preamble/SFD, 1 = dst, 2 = src, 3 = type/length
- field_last  output  1  current byte is the last byte of its field
- busy  output  1  header in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse: the final header byte was accepted

## Operation
- States: IDLE, PRE, SFD, DST, SRC, TYPE. A 3-bit byte counter indexes bytes within a field.
- A transfer occurs on a rising edge where data_valid=1 and data_ready=1.
- IDLE with start=1: go to PRE, counter=0, data_valid=1, data_out=0x55.
- PRE: each transfer increments the counter. The transfer at counter=6 goes to SFD with data_out=0xD5.
- SFD: transfer goes to DST, counter=0, data_out=DST_ADDR[47:40].
- DST: byte k drives DST_ADDR[47-8k -: 8], k=0..5. The transfer at k=5 goes to SRC, which sends SRC_ADDR the same way.
- SRC: the transfer at k=5 goes to TYPE, which sends TYPE_LENGTH[15:8] and then [7:0].
- TYPE: the transfer at k=1 goes to IDLE with data_valid=0, done=1.
- field_last=1 on PRE/SFD byte 0xD5, DST k=5, SRC k=5 and TYPE k=1; otherwise 0.
- Stall: with data_valid=1 and data_ready=0, data_out, field, field_last and state hold unchanged. data_valid never drops mid-header except on abort or reset.
- start while busy: ignored, no queuing.
- abort=1 in any non-IDLE state: next edge goes to IDLE, data_valid=0, done=0. Abort has priority over a simultaneous transfer. Abort in IDLE has no effect and does not block a simultaneous start; in that case start wins.
- reset_n=0: next edge forces IDLE, counter=0 and all outputs to reset values, regardless of start, abort or an in-flight header.
- Reset values: data_out=0x00, data_valid=0, field=0, field_last=0, busy=0, done=0.
- All outputs are registered; none depend combinationally on inputs.

## Timing
- Start latency: start sampled high at edge N in IDLE gives data_valid=1 and data_out=0x55 after edge N.
- With data_ready held at 1, one byte transfers per cycle: 22 cycles from first valid to last. The final transfer occurs at edge N+22, and done=1 with busy=0 after edge N+22.
- done lasts exactly one cycle. The block is in IDLE during the done cycle, so a start sampled in that cycle is accepted. The minimum gap between headers is therefore one idle cycle.
- busy rises and falls on the same edges as data_valid. Each header has at most one done pulse, and none if aborted.

## Test plan
- Reset, then start pulse with data_ready=1 -> bytes 55×7, D5, 01 02 03 04 05 06, FF FE FD FC FB FA, 08 00 on 22 consecutive cycles. field_last on bytes 8, 14, 20 and 22; done high for one cycle after the last byte.
- data_ready toggled pseudo-randomly (≈50%) -> identical 22-byte sequence. data_out/field held stable during every stall cycle; done only after byte 0x00 is accepted.
- Loopback into the receive-side header parser, enable=1 -> parser asserts preamble, dst, src and type/length valid in order.
- abort asserted during the SRC byte 0xFC with data_ready=1 -> data_valid=0 next cycle, no done. A subsequent start restarts from 0x55.
- start held high across a full header -> second header begins the cycle after done (0x55 valid one cycle after the done edge). Start pulses while busy are ignored.
- reset_n=0 for one cycle during DST byte 0x03 -> all outputs at reset values the next cycle. The next start produces a full, correct header.
